fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue on the consumer side of the fetch stage. It captures the `if_pc`/`if_inst` pair the fetch stage presents each un-stalled cycle and buffers it in a small circular FIFO. It hands entries to decode through a valid/ready handshake, and holds the fetch stage via `pc_stall` when full. It sits between the fetch stage and the ID pipeline stage and is cleared by the same `flush_i` that redirects the PC.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `NOP_INST`, 32'h0000_0013: instruction driven on `id_inst` when empty.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_pc`  in  32  PC presented by fetch stage.
- `if_inst`  in  32  instruction presented by fetch stage.
- `if_valid`  in  1  fetch pair is meaningful this cycle (0 during fetch bubbles).
- `flush_i`  in  1  redirect: discard all entries and the current fetch.
- `pc_stall`  out  1  hold fetch PC; equals queue full.
- `id_valid`  out  1  head entry available to decode.
- `id_ready`  in  1  decode accepts head this cycle.
- `id_pc`  out  32  head PC.
- `id_inst`  out  32  head instruction.
- `occupancy`  out  $clog2(DEPTH)+1  current entry count.

## Operation
- Storage: DEPTH × 64-bit array, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits with natural wrap. `count` register 0..DEPTH.
- enq = `if_valid` & !`pc_stall` & !`flush_i`; write {if_pc, if_inst} at `wp`, then `wp` += 1.
- deq = `id_valid` & `id_ready`; `rp` += 1.
- `count` next = count + enq − deq; simultaneous enq and deq leaves count unchanged.
- Full (count == DEPTH): `pc_stall`=1, enq blocked. The fetch stage holds the PC, so the same pair is re-presented and nothing is lost. A deq in the full cycle proceeds; enq resumes next cycle.
- Empty (count == 0): `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0 (no-bypass build).
- Flush has priority over both enq and deq. Next edge: count=0, wp=rp=0. The pair presented in the flush cycle is dropped. `id_valid` is forced 0 combinationally during the flush cycle.
- `id_pc`/`id_inst` are combinational reads of array[rp]. Array contents are not reset.
- Reset asserted mid-operation: pointers and count clear immediately (async). Behaviour matches flush, without waiting for an edge.

## Timing
- Reset values: `pc_stall`=0, `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0, `occupancy`=0.
- Enqueue-to-visible latency: 1 cycle (entry written at edge N appears on `id_*` after edge N) when the bypass is compiled out.
- `pc_stall` and `id_valid` depend only on registered count plus `flush_i`. There is no combinational path from `id_ready` to `pc_stall`.
- Throughput: one enq and one deq per cycle sustained at any occupancy below DEPTH.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count==0 and `if_valid` & !`flush_i`, the incoming pair drives `id_*` directly with `id_valid`=1 (zero latency).
  - If `id_ready`=1 in that cycle, the pair is consumed and not written (count stays 0).
  - Otherwise the pair is written normally.
- Not defined: no bypass; empty queue always shows `id_valid`=0; minimum latency 1 cycle.

## Test plan
- Reset, then 4 fetches pc=0x00,0x04,0x08,0x0C with `id_ready`=0 -> occupancy 4, `pc_stall`=1. The 5th presented pair (pc=0x10) is not written.
- From full, `id_ready`=1 for one cycle -> `id_pc`=0x00 consumed, occupancy 3, `pc_stall`=0. Next cycle pc=0x10 enqueued, occupancy 4.
- Continuous `if_valid` and `id_ready` for 20 cycles from pc=0 -> `id_pc` sequence 0x00,0x04,…,0x48 in order with correct wrap of pointers. Occupancy stays ≤1.
- Occupancy 3, then `flush_i`=1 with `if_valid`=1 and `id_ready`=1 -> `id_valid`=0 that cycle. Next cycle occupancy 0, `id_inst`=0x00000013, no entry consumed.
- Assert `rst` asynchronously mid-cycle at occupancy 2 -> `id_valid`, `occupancy`, `pc_stall` drop to 0 before the next clock edge.
- Bypass build, empty queue, `if_pc`=0x100, `if_inst`=0x00A00093, `id_ready`=1 -> same cycle `id_valid`=1, `id_pc`=0x100. Occupancy remains 0. Non-bypass build: `id_valid`=0 that cycle, `id_pc`=0x100 one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch queue between the fetch stage and the ID stage. Each
// cycle the fetch stage presents a meaningful {if_pc, if_inst} pair, the pair
// is captured into a small circular FIFO. Decode takes entries from the head
// through a valid/ready handshake. When the FIFO is full, pc_stall holds the
// fetch PC so the same pair is presented again and nothing is lost. flush_i
// (the same redirect that steers the PC) empties the queue and drops the pair
// presented in that cycle.
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN  when defined, an empty queue forwards the incoming
//                          fetch pair straight to id_* (zero latency). If
//                          decode accepts it that cycle, the pair is never
//                          written. When undefined, an entry becomes visible
//                          one cycle after it is written.
//
// Parameters:
//   DEPTH     number of entries (power of two, >= 2)
//   NOP_INST  instruction shown on id_inst while nothing is valid
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   if_pc      PC presented by the fetch stage
//   if_inst    instruction presented by the fetch stage
//   if_valid   fetch pair is meaningful this cycle
//   flush_i    redirect: discard all entries and the current fetch
//   pc_stall   queue full, fetch must hold its PC
//   id_valid   head entry available to decode
//   id_ready   decode accepts the head this cycle
//   id_pc      head PC
//   id_inst    head instruction
//   occupancy  current number of stored entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_inst,
    input  logic                     if_valid,
    input  logic                     flush_i,
    output logic                     pc_stall,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic        full;
    logic        empty;
    logic        bypass;
    logic        enq;
    logic        deq;
    logic [63:0] head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rp_q];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & if_valid & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Handshake and output selection. Flush suppresses id_valid in the same
    // cycle so decode never consumes an entry that is being discarded. A
    // dequeue only advances the read pointer when the head comes from the
    // array; a bypassed pair that decode takes is simply never written.
    always_comb begin
        pc_stall = full;
        id_valid = ~flush_i & (~empty | bypass);
        id_pc    = 32'h0;
        id_inst  = NOP_INST;
        if (!empty) begin
            id_pc   = head[63:32];
            id_inst = head[31:0];
        end else if (bypass) begin
            id_pc   = if_pc;
            id_inst = if_inst;
        end
        deq = ~flush_i & ~empty & id_ready;
        enq = if_valid & ~full & ~flush_i & ~(bypass & id_ready);
    end

    // Pointer and count next-state. Flush takes priority over any enqueue
    // or dequeue and returns both pointers to zero.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wp_d = wp_q + PW'(1);
            end
            if (deq) begin
                rp_d = rp_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Control state clears asynchronously so the queue looks empty as soon
    // as reset is raised, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage array. It has no reset: stale contents are never visible
    // because the outputs fall back to the NOP pair while the count is zero.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wp_q] <= {if_pc, if_inst};
        end
    end

    assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed and random stimulus for fetch_queue. A queue of {pc, inst} pairs
// models the FIFO, and the expected outputs for every cycle are derived from
// that queue.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        flush_i;
    logic        pc_stall;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  occupancy;

    int vectors;
    int miscompares;
    logic [63:0] model[$];

    fetch_queue #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .flush_i   (flush_i),
        .pc_stall  (pc_stall),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .occupancy (occupancy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, and reported when it does not hold.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // outputs against the model, then advance the model past the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic rdy,
                                 input logic fl);
        int size;
        bit byp;
        bit expValid;
        bit doEnq;
        bit doDeq;
        @(negedge clk);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush_i  = fl;
        #1;
        size     = model.size();
        byp      = BYP && (size == 0) && v && !fl;
        expValid = !fl && ((size > 0) || byp);
        checkOutput("pc_stall", 64'(pc_stall), 64'(size == DEPTH));
        checkOutput("id_valid", 64'(id_valid), 64'(expValid));
        checkOutput("occupancy", 64'(occupancy), 64'(size));
        if (size > 0) begin
            if (!fl) begin
                checkOutput("id_pair_head", {id_pc, id_inst}, model[0]);
            end
        end else if (byp) begin
            checkOutput("id_pair_bypass", {id_pc, id_inst}, {pc, inst});
        end else begin
            checkOutput("id_pair_empty", {id_pc, id_inst}, {32'h0, NOP_INST});
        end
        if (fl) begin
            model.delete();
        end else begin
            doDeq = expValid && rdy && (size > 0);
            doEnq = v && (size < DEPTH) && !(byp && rdy);
            if (doDeq) begin
                void'(model.pop_front());
            end
            if (doEnq) begin
                model.push_back({pc, inst});
            end
        end
        @(posedge clk);
    endtask

    initial begin
        int pcNext;
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        if_valid = 1'b0;
        if_pc    = 32'h0;
        if_inst  = 32'h0;
        id_ready = 1'b0;
        flush_i  = 1'b0;

        // Reset values.
        @(negedge clk);
        #1;
        checkOutput("reset_pc_stall", 64'(pc_stall), 64'(0));
        checkOutput("reset_id_valid", 64'(id_valid), 64'(0));
        checkOutput("reset_occupancy", 64'(occupancy), 64'(0));
        checkOutput("reset_id_pair", {id_pc, id_inst}, {32'h0, NOP_INST});
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        // Fill to full, then present a fifth pair that must not be written.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h10, 32'hA000_0004, 1'b0, 1'b0);
        // Dequeue from full: head 0x00 leaves, 0x10 still blocked this cycle.
        applyStimulus(1'b1, 32'h10, 32'hA000_0004, 1'b1, 1'b0);
        // 0x10 now enqueues, queue back to 4.
        applyStimulus(1'b1, 32'h10, 32'hA000_0004, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Streaming: enqueue and dequeue every cycle.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Occupancy 3, then flush with a valid fetch and a ready decode.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h300, 32'hC000_0100, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle at occupancy 2.
        applyStimulus(1'b1, 32'h400, 32'hD000_0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h404, 32'hD000_0001, 1'b0, 1'b0);
        @(negedge clk);
        if_valid = 1'b0;
        id_ready = 1'b0;
        #1;
        checkOutput("pre_async_occupancy", 64'(occupancy), 64'(model.size()));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_id_valid", 64'(id_valid), 64'(0));
        checkOutput("async_occupancy", 64'(occupancy), 64'(0));
        checkOutput("async_pc_stall", 64'(pc_stall), 64'(0));
        model.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Empty queue with a ready decode: bypass or one-cycle latency.
        applyStimulus(1'b1, 32'h100, 32'h00A0_0093, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        pcNext = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            logic v;
            logic rdy;
            logic fl;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            applyStimulus(v, 32'(pcNext), $urandom, rdy, fl);
            if (v && !pc_stall) begin
                pcNext = pcNext + 4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
